// File: rtl/uart_cmd_bridge_if.sv
// Bus side of the UART command bridge: one request (read or write) held
// until the slave returns bus_ack.
interface uart_cmd_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;
  logic              bus_re;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (output bus_addr, bus_wdata, bus_we, bus_re,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_addr, bus_wdata, bus_we, bus_re,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/uart_cmd_bridge.sv
// ASCII command bridge: "R<addr>" / "W<addr><data>" in hex from the UART RX
// FIFO become one bus access; the result goes back out the UART TX FIFO.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | wait for a command letter, skip CR/LF/space
// ADDR  | collect ADDR_W/4 hex address digits
// DATA  | collect DATA_W/4 hex write-data digits
// BUS   | hold bus_re/bus_we until bus_ack or the wait timer expires
// RESP  | push the response bytes (hex read data, 'K' or '!')
// ERR   | push a single '?' for a malformed command
module uart_cmd_bridge #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rx_empty,
  input  logic [7:0]              r_data,
  output logic                    rd_uart,
  input  logic                    tx_full,
  output logic [7:0]              w_data,
  output logic                    wr_uart,
  output logic                    busy,
  uart_cmd_bridge_if.master       bus
);

  localparam int ADIG = ADDR_W / 4;
  localparam int DDIG = DATA_W / 4;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] BUS  = 3'd3;
  localparam logic [2:0] RESP = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;

  logic [2:0]        state;
  logic              op_rd;
  logic [3:0]        dig_cnt;
  logic [15:0]       tmo_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] resp_q;
  logic [DATA_W-1:0] resp_nxt;
  logic [4:0]        rx_hex;
  logic              fetch;

  // {valid, nibble} for an ASCII hex digit of either case
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      hex_dec = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      hex_dec = {1'b1, c[3:0] + 4'd9};
    else
      hex_dec = 5'd0;
  endfunction

  // nibble to uppercase ASCII hex
  function automatic logic [7:0] hex_enc(input logic [3:0] n);
    hex_enc = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // RX is only popped while parsing; reset gating keeps the strobe low even
  // though IDLE is a fetch state
  assign fetch    = (state == IDLE) || (state == ADDR) || (state == DATA);
  assign rd_uart  = reset_n & fetch & ~rx_empty;
  assign wr_uart  = ((state == RESP) || (state == ERR)) & ~tx_full;
  assign busy     = (state != IDLE);
  assign rx_hex   = hex_dec(r_data);
  assign resp_nxt = resp_q << 4;

  // bus request is a pure decode of BUS so an async reset drops it at once
  assign bus.bus_re    = (state == BUS) & op_rd;
  assign bus.bus_we    = (state == BUS) & ~op_rd;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

  // command parser, bus sequencer and response generator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_rd   <= 1'b0;
      dig_cnt <= '0;
      tmo_cnt <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      w_data  <= '0;
    end else begin
      case (state)
        IDLE: if (rd_uart) begin
          dig_cnt <= '0;
          if (r_data == 8'h52 || r_data == 8'h72) begin
            op_rd <= 1'b1;
            state <= ADDR;
          end else if (r_data == 8'h57 || r_data == 8'h77) begin
            op_rd <= 1'b0;
            state <= ADDR;
          end else if (!(r_data == 8'h0D || r_data == 8'h0A || r_data == 8'h20)) begin
            w_data <= 8'h3F;
            state  <= ERR;
          end
        end
        ADDR: if (rd_uart) begin
          if (!rx_hex[4]) begin
            w_data <= 8'h3F;
            state  <= ERR;
          end else begin
            addr_q <= (addr_q << 4) | ADDR_W'(rx_hex[3:0]);
            if (dig_cnt == 4'(ADIG - 1)) begin
              dig_cnt <= '0;
              tmo_cnt <= 16'(TIMEOUT - 1);
              state   <= op_rd ? BUS : DATA;
            end else begin
              dig_cnt <= dig_cnt + 4'd1;
            end
          end
        end
        DATA: if (rd_uart) begin
          if (!rx_hex[4]) begin
            w_data <= 8'h3F;
            state  <= ERR;
          end else begin
            wdata_q <= (wdata_q << 4) | DATA_W'(rx_hex[3:0]);
            if (dig_cnt == 4'(DDIG - 1)) begin
              dig_cnt <= '0;
              tmo_cnt <= 16'(TIMEOUT - 1);
              state   <= BUS;
            end else begin
              dig_cnt <= dig_cnt + 4'd1;
            end
          end
        end
        BUS: begin
          if (bus.bus_ack) begin
            if (op_rd) begin
              resp_q  <= bus.bus_rdata;
              w_data  <= hex_enc(bus.bus_rdata[DATA_W-1 -: 4]);
              dig_cnt <= 4'(DDIG - 1);
            end else begin
              w_data  <= 8'h4B;
              dig_cnt <= '0;
            end
            state <= RESP;
          end else if (tmo_cnt == '0) begin
            w_data  <= 8'h21;
            dig_cnt <= '0;
            state   <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt - 16'd1;
          end
        end
        // dig_cnt counts the response bytes still to follow the current one
        RESP: if (wr_uart) begin
          if (dig_cnt == '0) begin
            state <= IDLE;
          end else begin
            dig_cnt <= dig_cnt - 4'd1;
            resp_q  <= resp_nxt;
            w_data  <= hex_enc(resp_nxt[DATA_W-1 -: 4]);
          end
        end
        ERR: if (wr_uart) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
